// File: rtl/viterbi_chk_pkg.sv
// Shared types, default sizing and helpers for the Viterbi BER checker.
package viterbi_chk_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } chk_state_e;

  localparam int DEF_DEPTH    = 64;
  localparam int DEF_CNT_W    = 16;
  localparam int DEF_WIN_LEN  = 256;
  localparam int DEF_WIN_W    = 9;
  localparam int DEF_ALARM_TH = 4;

  // Increment that sticks at max_val instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] max_val);
    logic [31:0] res;
    if (val >= max_val) begin
      res = max_val;
    end else begin
      res = val + 32'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/viterbi_ber_checker_if.sv
// Stimulus/result bundle between the bench chain and the BER checker.
interface viterbi_ber_checker_if
  import viterbi_chk_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W,
  parameter int WIN_W = DEF_WIN_W
);
  logic             clear_i;
  logic             ref_valid_i;
  logic             ref_bit_i;
  logic             dec_valid_i;
  logic             dec_bit_i;
  logic [CNT_W-1:0] bits_checked_o;
  logic [CNT_W-1:0] bit_errors_o;
  logic             mismatch_o;
  logic [WIN_W-1:0] win_errors_o;
  logic             win_done_o;
  logic             win_alarm_o;
  logic             fault_o;
  logic [1:0]       state_o;

  modport master (
    output clear_i, ref_valid_i, ref_bit_i, dec_valid_i, dec_bit_i,
    input  bits_checked_o, bit_errors_o, mismatch_o, win_errors_o,
           win_done_o, win_alarm_o, fault_o, state_o
  );

  modport slave (
    input  clear_i, ref_valid_i, ref_bit_i, dec_valid_i, dec_bit_i,
    output bits_checked_o, bit_errors_o, mismatch_o, win_errors_o,
           win_done_o, win_alarm_o, fault_o, state_o
  );
endinterface

// File: rtl/ber_ref_fifo.sv
// 1-bit reference FIFO. The caller only raises push_i/pop_i when the
// operation is legal (pop when not empty, push when not full or popping).
module ber_ref_fifo
  import viterbi_chk_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic clk,
  input  logic rst,
  input  logic flush_i,
  input  logic push_i,
  input  logic push_bit_i,
  input  logic pop_i,
  output logic head_bit_o,
  output logic full_o,
  output logic empty_o
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);

  logic [DEPTH-1:0] r_mem;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;

  // Bit storage; contents behind the pointers are don't-care so no reset.
  always_ff @(posedge clk) begin
    if (push_i) begin
      r_mem[r_wr_ptr] <= push_bit_i;
    end
  end

  // Pointer and occupancy bookkeeping with flush back to empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= {PTR_W{1'b0}};
      r_rd_ptr <= {PTR_W{1'b0}};
      r_count  <= {(PTR_W+1){1'b0}};
    end else if (flush_i) begin
      r_wr_ptr <= {PTR_W{1'b0}};
      r_rd_ptr <= {PTR_W{1'b0}};
      r_count  <= {(PTR_W+1){1'b0}};
    end else begin
      if (push_i) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (pop_i) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      case ({push_i, pop_i})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  assign head_bit_o = r_mem[r_rd_ptr];
  assign full_o     = (r_count == CNT_FULL);
  assign empty_o    = (r_count == {(PTR_W+1){1'b0}});
endmodule

// File: rtl/viterbi_ber_checker.sv
// Compares decoder output against buffered encoder input and keeps
// saturating totals, per-window error figures and a sticky fault flag.
module viterbi_ber_checker
  import viterbi_chk_pkg::*;
#(
  parameter int DEPTH    = DEF_DEPTH,
  parameter int CNT_W    = DEF_CNT_W,
  parameter int WIN_LEN  = DEF_WIN_LEN,
  parameter int WIN_W    = DEF_WIN_W,
  parameter int ALARM_TH = DEF_ALARM_TH
) (
  input logic                  clk,
  input logic                  rst,
  viterbi_ber_checker_if.slave bus
);
  localparam int               WC_W       = $clog2(WIN_LEN + 1);
  localparam logic [WC_W-1:0]  WC_ONE     = WC_W'(1);
  localparam logic [WC_W-1:0]  WIN_LEN_W  = WC_W'(WIN_LEN);
  localparam logic [WIN_W-1:0] ALARM_TH_W = WIN_W'(ALARM_TH);
  localparam logic [31:0]      CNT_MAX    = (32'd1 << CNT_W) - 32'd1;

  chk_state_e       r_state;
  chk_state_e       w_state_nxt;

  logic [CNT_W-1:0] r_bits_checked;
  logic [CNT_W-1:0] r_bit_errors;
  logic             r_mismatch;
  logic [WC_W-1:0]  r_win_cnt;
  logic [WIN_W-1:0] r_win_err;
  logic [WIN_W-1:0] r_win_errors;
  logic             r_win_done;
  logic             r_win_alarm;
  logic             r_fault;

  logic             w_head_bit;
  logic             w_full;
  logic             w_empty;
  logic             w_pop_ok;
  logic             w_push_ok;
  logic             w_fifo_push;
  logic             w_fifo_pop;
  logic             w_overflow;
  logic             w_underflow;
  logic             w_fault_ev;
  logic             w_compare;
  logic             w_bit_err;
  logic [CNT_W-1:0] w_chk_inc;
  logic [CNT_W-1:0] w_err_inc;
  logic [WC_W-1:0]  w_win_cnt_inc;
  logic [WIN_W-1:0] w_win_err_inc;
  logic             w_win_close;

  ber_ref_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .flush_i    (bus.clear_i),
    .push_i     (w_fifo_push),
    .push_bit_i (bus.ref_bit_i),
    .pop_i      (w_fifo_pop),
    .head_bit_o (w_head_bit),
    .full_o     (w_full),
    .empty_o    (w_empty)
  );

  // Classify this cycle's FIFO traffic: legal push/pop, overflow, underflow, compare.
  always_comb begin
    w_pop_ok    = bus.dec_valid_i & ~w_empty;
    // A pop frees a slot in the same cycle, so push+pop while full is legal.
    w_push_ok   = bus.ref_valid_i & (~w_full | w_pop_ok);
    w_overflow  = bus.ref_valid_i & w_full & ~w_pop_ok;
    w_underflow = bus.dec_valid_i & w_empty;
    w_fault_ev  = w_overflow | w_underflow;
    // Clear drops all valids in the same cycle.
    w_fifo_push = w_push_ok & ~bus.clear_i;
    w_fifo_pop  = w_pop_ok & ~bus.clear_i;
    // In FAULT the FIFO keeps moving but nothing is counted.
    w_compare   = w_pop_ok & (r_state != FAULT);
    w_bit_err   = w_compare & (w_head_bit ^ bus.dec_bit_i);
  end

  // Candidate next values for the saturating totals and the window.
  always_comb begin
    w_chk_inc     = CNT_W'(sat_inc(32'(r_bits_checked), CNT_MAX));
    w_err_inc     = CNT_W'(sat_inc(32'(r_bit_errors), CNT_MAX));
    w_win_cnt_inc = r_win_cnt + WC_ONE;
    w_win_err_inc = r_win_err + {{(WIN_W-1){1'b0}}, w_bit_err};
    w_win_close   = w_compare & (w_win_cnt_inc == WIN_LEN_W);
  end

  // Next-state logic; FAULT is left only through clear.
  always_comb begin
    w_state_nxt = r_state;
    if (bus.clear_i) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_fault_ev) begin
            w_state_nxt = FAULT;
          end else if (w_compare) begin
            w_state_nxt = RUN;
          end else begin
            w_state_nxt = IDLE;
          end
        end
        RUN: begin
          if (w_fault_ev) begin
            w_state_nxt = FAULT;
          end else begin
            w_state_nxt = RUN;
          end
        end
        FAULT:   w_state_nxt = FAULT;
        default: w_state_nxt = FAULT;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Totals, compare pulse, window registers and sticky fault.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bits_checked <= {CNT_W{1'b0}};
      r_bit_errors   <= {CNT_W{1'b0}};
      r_mismatch     <= 1'b0;
      r_win_cnt      <= {WC_W{1'b0}};
      r_win_err      <= {WIN_W{1'b0}};
      r_win_errors   <= {WIN_W{1'b0}};
      r_win_done     <= 1'b0;
      r_win_alarm    <= 1'b0;
      r_fault        <= 1'b0;
    end else if (bus.clear_i) begin
      r_bits_checked <= {CNT_W{1'b0}};
      r_bit_errors   <= {CNT_W{1'b0}};
      r_mismatch     <= 1'b0;
      r_win_cnt      <= {WC_W{1'b0}};
      r_win_err      <= {WIN_W{1'b0}};
      r_win_errors   <= {WIN_W{1'b0}};
      r_win_done     <= 1'b0;
      r_win_alarm    <= 1'b0;
      r_fault        <= 1'b0;
    end else begin
      r_mismatch <= w_bit_err;
      r_win_done <= w_win_close;
      r_fault    <= r_fault | w_fault_ev;
      if (w_compare) begin
        r_bits_checked <= w_chk_inc;
        if (w_bit_err) begin
          r_bit_errors <= w_err_inc;
        end
        if (w_win_close) begin
          // The closing compare's own error is part of this window.
          r_win_errors <= w_win_err_inc;
          r_win_alarm  <= (w_win_err_inc > ALARM_TH_W);
          r_win_cnt    <= {WC_W{1'b0}};
          r_win_err    <= {WIN_W{1'b0}};
        end else begin
          r_win_cnt <= w_win_cnt_inc;
          r_win_err <= w_win_err_inc;
        end
      end
    end
  end

  assign bus.bits_checked_o = r_bits_checked;
  assign bus.bit_errors_o   = r_bit_errors;
  assign bus.mismatch_o     = r_mismatch;
  assign bus.win_errors_o   = r_win_errors;
  assign bus.win_done_o     = r_win_done;
  assign bus.win_alarm_o    = r_win_alarm;
  assign bus.fault_o        = r_fault;
  assign bus.state_o        = r_state;
endmodule

// File: tb/tb_viterbi_ber_checker.sv
// Self-checking bench: directed scenarios plus random traffic against a
// queue-based reference model; a second CNT_W=4 instance shadows the
// same stimulus to exercise counter saturation.
module tb_viterbi_ber_checker;
  localparam int DEPTH = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  viterbi_ber_checker_if #(.CNT_W(16), .WIN_W(9)) bus_a ();
  viterbi_ber_checker_if #(.CNT_W(4),  .WIN_W(9)) bus_b ();

  assign bus_b.clear_i     = bus_a.clear_i;
  assign bus_b.ref_valid_i = bus_a.ref_valid_i;
  assign bus_b.ref_bit_i   = bus_a.ref_bit_i;
  assign bus_b.dec_valid_i = bus_a.dec_valid_i;
  assign bus_b.dec_bit_i   = bus_a.dec_bit_i;

  viterbi_ber_checker #(.DEPTH(64), .CNT_W(16), .WIN_LEN(256), .WIN_W(9), .ALARM_TH(4)) u_dut (
    .clk (clk), .rst (rst), .bus (bus_a)
  );
  viterbi_ber_checker #(.DEPTH(64), .CNT_W(4), .WIN_LEN(256), .WIN_W(9), .ALARM_TH(4)) u_dut_small (
    .clk (clk), .rst (rst), .bus (bus_b)
  );

  // Reference model state
  bit q[$];
  int m_chk, m_err, m_mis, m_wdone, m_wcnt, m_wrun, m_werr, m_alarm, m_fault, m_state;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;
  int n_done, n_mis, done_c;
  bit bits[0:299];

  function automatic logic [31:0] sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_chk = 0; m_err = 0; m_mis = 0; m_wdone = 0; m_wcnt = 0;
    m_wrun = 0; m_werr = 0; m_alarm = 0; m_fault = 0; m_state = 0;
  endtask

  // One clock of spec behaviour: pop (if any) happens before push.
  task automatic model_cycle(input bit rv, input bit rb, input bit dv, input bit db, input bit cl);
    bit under, over, cmp, e, h;
    if (cl) begin
      model_reset();
    end else begin
      m_mis = 0; m_wdone = 0;
      under = dv && (q.size() == 0);
      cmp = 0; e = 0; over = 0;
      if (dv && q.size() > 0) begin
        h = q.pop_front();
        if (m_state != 2) begin
          cmp = 1;
          e = (h != db);
        end
      end
      if (rv) begin
        if (q.size() < DEPTH) q.push_back(rb);
        else over = 1;
      end
      if (cmp) begin
        m_chk++;
        m_err += e;
        m_mis = e;
        m_wcnt++;
        m_wrun += e;
        if (m_wcnt == 256) begin
          m_werr = m_wrun;
          m_alarm = (m_wrun > 4);
          m_wdone = 1;
          m_wcnt = 0;
          m_wrun = 0;
        end
      end
      if (over || under) begin
        m_fault = 1;
        m_state = 2;
      end else if (cmp && m_state == 0) begin
        m_state = 1;
      end
    end
  endtask

  task automatic check_all();
    chk("bits_checked", 32'(bus_a.bits_checked_o), sat(m_chk, 65535));
    chk("bit_errors",   32'(bus_a.bit_errors_o),   sat(m_err, 65535));
    chk("mismatch",     32'(bus_a.mismatch_o),     m_mis);
    chk("win_errors",   32'(bus_a.win_errors_o),   m_werr);
    chk("win_done",     32'(bus_a.win_done_o),     m_wdone);
    chk("win_alarm",    32'(bus_a.win_alarm_o),    m_alarm);
    chk("fault",        32'(bus_a.fault_o),        m_fault);
    chk("state",        32'(bus_a.state_o),        m_state);
    chk("small_checked", 32'(bus_b.bits_checked_o), sat(m_chk, 15));
    chk("small_errors",  32'(bus_b.bit_errors_o),    sat(m_err, 15));
  endtask

  task automatic step(input bit rv, input bit rb, input bit dv, input bit db, input bit cl);
    bus_a.ref_valid_i = rv;
    bus_a.ref_bit_i   = rb;
    bus_a.dec_valid_i = dv;
    bus_a.dec_bit_i   = db;
    bus_a.clear_i     = cl;
    model_cycle(rv, rb, dv, db, cl);
    @(posedge clk);
    #1;
    check_all();
    n_done += int'(bus_a.win_done_o);
    n_mis  += int'(bus_a.mismatch_o);
  endtask

  initial begin
    bit rv, rb, dv, db, cl;
    bus_a.ref_valid_i = 1'b0;
    bus_a.ref_bit_i   = 1'b0;
    bus_a.dec_valid_i = 1'b0;
    bus_a.dec_bit_i   = 1'b0;
    bus_a.clear_i     = 1'b0;
    model_reset();

    // Reset state
    @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    rst = 1'b0;

    // A: 300 random bits replayed 20 cycles later, no errors
    for (int i = 0; i < 300; i++) bits[i] = 1'($urandom);
    n_done = 0; n_mis = 0;
    for (int c = 0; c < 320; c++) begin
      step(c < 300, (c < 300) ? bits[c] : 1'b0, c >= 20, (c >= 20) ? bits[c-20] : 1'b0, 1'b0);
    end
    chk("A_checked", 32'(bus_a.bits_checked_o), 32'd300);
    chk("A_errors", 32'(bus_a.bit_errors_o), 32'd0);
    chk("A_done_pulses", n_done, 32'd1);
    chk("A_win_errors", 32'(bus_a.win_errors_o), 32'd0);
    chk("A_alarm", 32'(bus_a.win_alarm_o), 32'd0);

    // B: 256 bits with five inverted decodes -> alarm
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 256; i++) bits[i] = 1'($urandom);
    n_done = 0; n_mis = 0;
    for (int c = 0; c < 261; c++) begin
      int j;
      j = c - 5;
      db = 1'b0;
      if (j >= 0) db = bits[j] ^ ((j == 10) || (j == 50) || (j == 90) || (j == 130) || (j == 170));
      step(c < 256, (c < 256) ? bits[c] : 1'b0, j >= 0, db, 1'b0);
    end
    chk("B_errors", 32'(bus_a.bit_errors_o), 32'd5);
    chk("B_mis_pulses", n_mis, 32'd5);
    chk("B_done_pulses", n_done, 32'd1);
    chk("B_win_errors", 32'(bus_a.win_errors_o), 32'd5);
    chk("B_alarm", 32'(bus_a.win_alarm_o), 32'd1);

    // C: underflow -> FAULT, counters frozen; FIFO still moves; clear recovers
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("C_fault", 32'(bus_a.fault_o), 32'd1);
    chk("C_state", 32'(bus_a.state_o), 32'd2);
    chk("C_checked", 32'(bus_a.bits_checked_o), 32'd256);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("C_frozen", 32'(bus_a.bits_checked_o), 32'd256);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    chk("C_clr_checked", 32'(bus_a.bits_checked_o), 32'd0);
    chk("C_clr_state", 32'(bus_a.state_o), 32'd0);
    chk("C_clr_fault", 32'(bus_a.fault_o), 32'd0);

    // D: overflow on the 65th push; then full push+pop keeps occupancy
    for (int i = 0; i < 65; i++) begin
      step(1'b1, 1'($urandom), 1'b0, 1'b0, 1'b0);
      if (i == 63) chk("D_no_fault_at_64", 32'(bus_a.fault_o), 32'd0);
    end
    chk("D_fault_at_65", 32'(bus_a.fault_o), 32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 64; i++) step(1'b1, 1'($urandom), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b1, 1'($urandom), 1'b1, q[0], 1'b0);
    chk("D_full_pushpop_fault", 32'(bus_a.fault_o), 32'd0);
    for (int i = 0; i < 64; i++) step(1'b0, 1'b0, 1'b1, q[0], 1'b0);
    chk("D_drain_checked", 32'(bus_a.bits_checked_o), 32'd74);
    chk("D_drain_fault", 32'(bus_a.fault_o), 32'd0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("D_empty_after_64", 32'(bus_a.fault_o), 32'd1);

    // E: 30 forced mismatches, small instance saturates at 15
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int c = 0; c < 31; c++) begin
      db = (c >= 1) ? ~q[0] : 1'b0;
      step(c < 30, 1'($urandom), c >= 1, db, 1'b0);
    end
    chk("E_small_errors", 32'(bus_b.bit_errors_o), 32'd15);
    chk("E_small_checked", 32'(bus_b.bits_checked_o), 32'd15);
    chk("E_big_errors", 32'(bus_a.bit_errors_o), 32'd30);

    // F: async reset after 100 compares, next window needs a full 256
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int c = 0; c < 101; c++) begin
      db = (c >= 1) ? (q[0] ^ ($urandom_range(0, 7) == 0)) : 1'b0;
      step(c < 100, 1'($urandom), c >= 1, db, 1'b0);
    end
    bus_a.ref_valid_i = 1'b0;
    bus_a.dec_valid_i = 1'b0;
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    rst = 1'b0;
    n_done = 0;
    done_c = -1;
    for (int c = 0; c < 257; c++) begin
      db = (c >= 1) ? (q[0] ^ ($urandom_range(0, 15) == 0)) : 1'b0;
      step(c < 256, 1'($urandom), c >= 1, db, 1'b0);
      if (bus_a.win_done_o && done_c < 0) done_c = c;
    end
    chk("F_done_pulses", n_done, 32'd1);
    chk("F_done_cycle", done_c, 32'd256);

    // G: random mixed traffic with occasional clears
    for (int c = 0; c < 400; c++) begin
      cl = ($urandom_range(0, 29) == 0);
      rv = $urandom_range(0, 1);
      dv = (q.size() > 0) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 9) == 0);
      db = (q.size() > 0) ? (q[0] ^ ($urandom_range(0, 5) == 0)) : 1'($urandom);
      rb = 1'($urandom);
      step(rv, rb, dv, db, cl);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
